// File: rtl/ddr_tx_sched.sv
// Two-requester word scheduler feeding one ODDR2 pin: arbitrates per word, sends two bits per clock MSB first.
// Latency: the first pair appears one clock after acceptance; a word lasts DATA_W/2 clocks (+1 parity clock with DDR_TX_PARITY_EN).
// Backpressure: one ready per word, offered only in the ready window; a requester holds valid until it sees ready.
module ddr_tx_sched #(
   parameter int DATA_W     = 8,
   parameter bit IDLE_LEVEL = 1'b0,
   parameter bit PRIO_FIXED = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] a_data,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [DATA_W-1:0] b_data,
   input  logic              b_valid,
   output logic              b_ready,
   output logic              oddr_d0,
   output logic              oddr_d1,
   output logic              oddr_ce,
   output logic              oddr_r,
   output logic              busy,
   output logic              grant_b,
   output logic              word_start
);

   localparam int NPAIR = DATA_W / 2;
   localparam int CNT_W = (NPAIR > 1) ? $clog2(NPAIR) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NPAIR - 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAR} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] sh_q, sh_d;        // bits still to be sent, next pair at the top
   logic              grant_b_q, grant_b_d;
   logic              last_grant_q, last_grant_d;  // 1 = B was granted last
   logic              d0_q, d0_d;
   logic              d1_q, d1_d;
   logic              ce_q, ce_d;
   logic              busy_q, busy_d;
   logic              ws_q, ws_d;
   logic              oddr_r_q, oddr_r_d;
`ifdef DDR_TX_PARITY_EN
   logic              par_q, par_d;
`endif

   logic              win;
   logic              a_pref;
   logic              a_rdy_c, b_rdy_c;
   logic              accept;
   logic [DATA_W-1:0] sel_data;

   // State and output registers; reset discards any word in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         sh_q         <= '0;
         grant_b_q    <= 1'b0;
         last_grant_q <= 1'b1;
         d0_q         <= IDLE_LEVEL;
         d1_q         <= IDLE_LEVEL;
         ce_q         <= 1'b0;
         busy_q       <= 1'b0;
         ws_q         <= 1'b0;
         oddr_r_q     <= 1'b1;
`ifdef DDR_TX_PARITY_EN
         par_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sh_q         <= sh_d;
         grant_b_q    <= grant_b_d;
         last_grant_q <= last_grant_d;
         d0_q         <= d0_d;
         d1_q         <= d1_d;
         ce_q         <= ce_d;
         busy_q       <= busy_d;
         ws_q         <= ws_d;
         oddr_r_q     <= oddr_r_d;
`ifdef DDR_TX_PARITY_EN
         par_q        <= par_d;
`endif
      end
   end

   // Ready window and arbitration: A wins a conflict if fixed priority or B had the last word
   always_comb begin
      win = 1'b0;
      case (state_q)
         S_IDLE:  win = 1'b1;
`ifdef DDR_TX_PARITY_EN
         S_SHIFT: win = 1'b0;
         S_PAR:   win = 1'b1;
`else
         S_SHIFT: win = (cnt_q == CNT_LAST);
         S_PAR:   win = 1'b0;
`endif
         default: win = 1'b0;
      endcase
      a_pref  = PRIO_FIXED || last_grant_q;
      a_rdy_c = win && !reset && a_valid && (!b_valid || a_pref);
      b_rdy_c = win && !reset && b_valid && (!a_valid || !a_pref);
   end

   // Next state: a new word takes priority, otherwise step through pairs, then parity, then idle
   always_comb begin
      accept       = a_rdy_c || b_rdy_c;
      sel_data     = b_rdy_c ? b_data : a_data;
      state_d      = state_q;
      cnt_d        = cnt_q;
      sh_d         = sh_q;
      grant_b_d    = grant_b_q;
      last_grant_d = last_grant_q;
      d0_d         = IDLE_LEVEL;
      d1_d         = IDLE_LEVEL;
      ce_d         = 1'b0;
      busy_d       = 1'b0;
      ws_d         = 1'b0;
      oddr_r_d     = 1'b0;
`ifdef DDR_TX_PARITY_EN
      par_d        = par_q;
`endif
      if (accept) begin
         state_d      = S_SHIFT;
         cnt_d        = '0;
         sh_d         = sel_data << 2;
         grant_b_d    = b_rdy_c;
         last_grant_d = b_rdy_c;
         d0_d         = sel_data[DATA_W-1];
         d1_d         = sel_data[DATA_W-2];
         ce_d         = 1'b1;
         busy_d       = 1'b1;
         ws_d         = 1'b1;
`ifdef DDR_TX_PARITY_EN
         par_d        = ^sel_data;
`endif
      end else begin
         case (state_q)
            S_SHIFT: begin
               if (cnt_q != CNT_LAST) begin
                  cnt_d  = cnt_q + CNT_W'(1);
                  d0_d   = sh_q[DATA_W-1];
                  d1_d   = sh_q[DATA_W-2];
                  sh_d   = sh_q << 2;
                  ce_d   = 1'b1;
                  busy_d = 1'b1;
               end else begin
`ifdef DDR_TX_PARITY_EN
                  state_d = S_PAR;
                  d0_d    = par_q;
                  d1_d    = grant_b_q;
                  ce_d    = 1'b1;
                  busy_d  = 1'b1;
`else
                  state_d = S_IDLE;
`endif
               end
            end
            S_PAR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Output mapping
   always_comb begin
      a_ready    = a_rdy_c;
      b_ready    = b_rdy_c;
      oddr_d0    = d0_q;
      oddr_d1    = d1_q;
      oddr_ce    = ce_q;
      oddr_r     = oddr_r_q;
      busy       = busy_q;
      grant_b    = grant_b_q;
      word_start = ws_q;
   end

endmodule
